// File: rtl/emern_spi_host.sv
// SPI mode-0 host for the badGPU command port: byte stream in, MSB-first on MOSI, MISO captured per byte.
// Define GPU_INT_WAIT_EN to hold each transaction's CS until the synchronized GPU INT (screen_inactive) is high.
module emern_spi_host #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    input  logic       int_in,
    output logic       cs_n_out,
    output logic       sck_out,
    output logic       mosi_out,
    input  logic       miso_in
);

    typedef enum logic [2:0] {IDLE, WAIT_INT, SETUP, SHIFT, NEXT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD - 1);

    state_t     state;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [3:0] phase_cnt;
    logic       last_q;

`ifdef GPU_INT_WAIT_EN
    logic [1:0] int_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) int_sync <= '0;
        else        int_sync <= {int_sync[0], int_in};
    end
`else
    logic unused_int;
    assign unused_int = int_in;
`endif

    assign tx_ready = (state == IDLE) || (state == NEXT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx_shift  <= '0;
            rx_shift  <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            last_q    <= 1'b0;
            cs_n_out  <= 1'b1;
            sck_out   <= 1'b0;
            mosi_out  <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        tx_shift  <= tx_data;
                        last_q    <= tx_last;
                        busy      <= 1'b1;
                        phase_cnt <= '0;
`ifdef GPU_INT_WAIT_EN
                        state     <= WAIT_INT;
`else
                        state     <= SETUP;
                        cs_n_out  <= 1'b0;
                        mosi_out  <= tx_data[7];
`endif
                    end
                end
`ifdef GPU_INT_WAIT_EN
                WAIT_INT: begin
                    if (int_sync[1]) begin
                        state    <= SETUP;
                        cs_n_out <= 1'b0;
                        mosi_out <= tx_shift[7];
                    end
                end
`endif
                SETUP: begin
                    if (phase_cnt == SETUP_LAST) begin
                        state   <= SHIFT;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 4'd1;
                    end
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else if (!sck_out) begin
                        div_cnt  <= '0;
                        sck_out  <= 1'b1;
                        rx_shift <= {rx_shift[6:0], miso_in};
                    end else begin
                        // Falling edge: advance MOSI, and after bit 0 hand the captured byte out.
                        div_cnt  <= '0;
                        sck_out  <= 1'b0;
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        mosi_out <= tx_shift[6];
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data   <= rx_shift;
                            rx_valid  <= 1'b1;
                            phase_cnt <= '0;
                            state     <= last_q ? HOLD : NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        mosi_out <= tx_data[7];
                        last_q   <= tx_last;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        state    <= SHIFT;
                    end
                end
                HOLD: begin
                    if (phase_cnt == HOLD_LAST) begin
                        cs_n_out <= 1'b1;
                        state    <= GAP;
                    end else begin
                        phase_cnt <= phase_cnt + 4'd1;
                    end
                end
                GAP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
